writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 134 +++++++++++++
 tb/tb_writeback_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU results take priority, mul/div
// results queue in a 2-entry FIFO, a starvation counter forces a one-cycle drain.
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic [4:0]  reg_write,
  output logic [31:0] write_data,
  output logic        writeenable,
  output logic [31:0] busy,
  output logic [1:0]  fifo_count,
  output logic        err
);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [1:0]  starve, starve_next;

  logic [4:0]  q_rd [2];
  logic [31:0] q_data [2];
  logic [4:0]  q_rd_next [2];
  logic [31:0] q_data_next [2];
  logic [1:0]  count_next;

  logic        alu_acc, md_acc, pop, sel, starving, wr_idx;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] busy_next;
  logic        err_next;

  // Selection and handshakes depend only on registered state plus this cycle's inputs.
  always_comb begin
    alu_ready = (state == NORMAL);
    md_ready  = (fifo_count != 2'd2);
    alu_acc   = alu_valid && alu_ready;
    md_acc    = md_valid && md_ready;
    pop       = !alu_acc && (fifo_count != 2'd0);
    sel       = alu_acc || pop;
    sel_rd    = alu_acc ? alu_rd : q_rd[0];
    sel_data  = alu_acc ? alu_data : q_data[0];
    starving  = alu_acc && (fifo_count != 2'd0);
  end

  always_comb begin
    state_next  = state;
    starve_next = starve;
    unique case (state)
      NORMAL: begin
        if (starving) begin
          if (starve == 2'd3) state_next = DRAIN;
          else                starve_next = starve + 2'd1;
        end else begin
          starve_next = '0;
        end
      end
      DRAIN: begin
        state_next  = NORMAL;
        starve_next = '0;
      end
      default: begin
        state_next  = NORMAL;
        starve_next = '0;
      end
    endcase
  end

  // Head lives in slot 0; a pop shifts slot 1 down before the push lands behind the survivors.
  always_comb begin
    q_rd_next   = q_rd;
    q_data_next = q_data;
    wr_idx      = (fifo_count == (pop ? 2'd2 : 2'd1));
    if (pop) begin
      q_rd_next[0]   = q_rd[1];
      q_data_next[0] = q_data[1];
    end
    if (md_acc) begin
      q_rd_next[wr_idx]   = md_rd;
      q_data_next[wr_idx] = md_data;
    end
    count_next = fifo_count + {1'b0, md_acc} - {1'b0, pop};
  end

  // Clear before set so a reissue to the same register in the retiring cycle stays pending.
  always_comb begin
    busy_next = busy;
    if (pop && (q_rd[0] != 5'd0)) busy_next[q_rd[0]] = 1'b0;
    if (md_issue && (md_issue_rd != 5'd0)) busy_next[md_issue_rd] = 1'b1;
    err_next = err || (alu_acc && (alu_rd != 5'd0) && busy[alu_rd]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= NORMAL;
      starve      <= '0;
      fifo_count  <= '0;
      q_rd[0]     <= '0;
      q_rd[1]     <= '0;
      q_data[0]   <= '0;
      q_data[1]   <= '0;
      busy        <= '0;
      err         <= 1'b0;
      writeenable <= 1'b0;
      reg_write   <= '0;
      write_data  <= '0;
    end else begin
      state       <= state_next;
      starve      <= starve_next;
      fifo_count  <= count_next;
      q_rd        <= q_rd_next;
      q_data      <= q_data_next;
      busy        <= busy_next;
      err         <= err_next;
      writeenable <= sel && (sel_rd != 5'd0);
      if (sel) begin
        reg_write  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks of writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_issue, md_valid, md_ready;
  logic [4:0]  md_issue_rd, md_rd;
  logic [31:0] md_data;
  logic [4:0]  reg_write;
  logic [31:0] write_data;
  logic        writeenable;
  logic [31:0] busy;
  logic [1:0]  fifo_count;
  logic        err;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .reg_write(reg_write), .write_data(write_data), .writeenable(writeenable),
    .busy(busy), .fifo_count(fifo_count), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [36:0] mq [$];
  logic [31:0] m_busy;
  logic        m_err, m_drain, m_we;
  int          m_starv;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("writeenable", {31'd0, writeenable}, {31'd0, m_we});
    if (m_we) begin
      chk("reg_write", {27'd0, reg_write}, {27'd0, m_rd});
      chk("write_data", write_data, m_data);
    end
    chk("busy", busy, m_busy);
    chk("fifo_count", {30'd0, fifo_count}, 32'(mq.size()));
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    md_issue = 1'b0; md_issue_rd = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_busy = '0; m_err = 1'b0; m_drain = 1'b0; m_we = 1'b0; m_starv = 0;
    m_rd = '0; m_data = '0;
    chk("rst_reg_write", {27'd0, reg_write}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    check_regs();
    rst = 1'b1;
  endtask

  // One clock of stimulus: readies checked before the edge, registered outputs after.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mi, input logic [4:0] mir,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    logic        aacc, macc, fsrc, starving, sel;
    logic [36:0] h;
    logic [4:0]  srd;
    logic [31:0] sd;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    md_issue = mi; md_issue_rd = mir;
    md_valid = mv; md_rd = mr; md_data = md;
    #1;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, !m_drain});
    chk("md_ready", {31'd0, md_ready}, {31'd0, mq.size() < 2});
    aacc = av && !m_drain;
    macc = mv && (mq.size() < 2);
    fsrc = 1'b0; starving = 1'b0; sel = 1'b0; srd = '0; sd = '0;
    if (aacc) begin
      sel = 1'b1; srd = ard; sd = ad;
      if (ard != 0 && m_busy[ard]) m_err = 1'b1;
      starving = mq.size() > 0;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      sel = 1'b1; srd = h[36:32]; sd = h[31:0]; fsrc = 1'b1;
    end
    m_we = sel && (srd != 0);
    if (sel) begin m_rd = srd; m_data = sd; end
    if (fsrc && srd != 0) m_busy[srd] = 1'b0;
    if (mi && mir != 0) m_busy[mir] = 1'b1;
    if (macc) mq.push_back({mr, md});
    if (m_drain) begin
      m_drain = 1'b0; m_starv = 0;
    end else if (starving) begin
      if (m_starv == 3) m_drain = 1'b1;
      else m_starv++;
    end else begin
      m_starv = 0;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    do_reset();
    do_reset();

    // Plain ALU write
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("alu_we", {31'd0, writeenable}, 32'd1);
    chk("alu_rd", {27'd0, reg_write}, 32'd5);
    chk("alu_data", write_data, 32'hDEADBEEF);

    // Mul/div issue, later completion, busy tracking
    step(0, 0, 0, 1, 5'd7, 0, 0, 0);
    chk("busy7_set", {31'd0, busy[7]}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5'd7, 32'h12345678);
    chk("md_pushed", {30'd0, fifo_count}, 32'd1);
    chk("md_not_yet", {31'd0, writeenable}, 32'd0);
    chk("busy7_hold", {31'd0, busy[7]}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("md_we", {31'd0, writeenable}, 32'd1);
    chk("md_rd", {27'd0, reg_write}, 32'd7);
    chk("md_data", write_data, 32'h12345678);
    chk("busy7_clr", {31'd0, busy[7]}, 32'd0);

    // Starvation leads to a one-cycle drain
    step(1, 5'd1, 32'h11, 0, 0, 1, 5'd3, 32'h33);
    step(1, 5'd1, 32'h12, 0, 0, 1, 5'd4, 32'h44);
    chk("full_count", {30'd0, fifo_count}, 32'd2);
    chk("full_md_ready", {31'd0, md_ready}, 32'd0);
    step(1, 5'd1, 32'h13, 0, 0, 0, 0, 0);
    step(1, 5'd1, 32'h14, 0, 0, 0, 0, 0);
    step(1, 5'd1, 32'h15, 0, 0, 0, 0, 0);
    chk("drain_alu_ready", {31'd0, alu_ready}, 32'd0);
    step(1, 5'd1, 32'h16, 0, 0, 0, 0, 0);
    chk("drain_rd", {27'd0, reg_write}, 32'd3);
    chk("drain_data", write_data, 32'h33);
    chk("drain_over", {31'd0, alu_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("second_rd", {27'd0, reg_write}, 32'd4);

    // Writes to x0 are consumed silently
    step(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    chk("x0_alu_we", {31'd0, writeenable}, 32'd0);
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'hAAAA5555);
    chk("x0_push", {30'd0, fifo_count}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_pop", {30'd0, fifo_count}, 32'd0);
    chk("x0_md_we", {31'd0, writeenable}, 32'd0);

    // WAW violation is sticky until reset
    step(0, 0, 0, 1, 5'd9, 0, 0, 0);
    step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    chk("waw_err", {31'd0, err}, 32'd1);
    chk("waw_we", {31'd0, writeenable}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("waw_cleared", {31'd0, err}, 32'd0);

    // Reset with a full FIFO discards its contents
    step(1, 5'd2, 32'h22, 1, 5'd10, 1, 5'd10, 32'hA0);
    step(1, 5'd2, 32'h23, 1, 5'd11, 1, 5'd11, 32'hB0);
    chk("pre_rst_full", {30'd0, fifo_count}, 32'd2);
    do_reset();
    chk("post_rst_busy", busy, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("no_stale_we", {31'd0, writeenable}, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
             $urandom_range(2, 0) == 0, 5'($urandom_range(7, 0)),
             $urandom_range(1, 0) == 0, 5'($urandom_range(7, 0)), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
